// File: rtl/dmem_arbiter_pkg.sv
// Shared types and widths for the DMEM arbiter: state encoding, op-code widths
// and a packed memory-op record.
package dmem_arbiter_pkg;

    localparam int DATA_W      = 32;
    localparam int MEM_WRITE_W = 2;
    localparam int MEM_READ_W  = 3;

    typedef enum logic [1:0] {
        DARB_IDLE  = 2'd0,
        DARB_D_ACC = 2'd1,
        DARB_D_RSP = 2'd2
    } darb_state_e;

    typedef struct packed {
        logic [MEM_WRITE_W-1:0] wr;
        logic [MEM_READ_W-1:0]  rd;
    } mem_op_t;

    // Op codes are only ever interpreted as zero / non-zero.
    function automatic logic op_active(input mem_op_t op);
        return (op.wr != '0) || (op.rd != '0);
    endfunction

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating counter of consecutive blocked debug cycles; full_o forces a
// debug grant. Only instantiated when DMEM_ARB_STARVE_EN is defined.
module dmem_arb_starve_ctr #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic full_o
);

    localparam int              CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: combinational blocks assign every output a default first, so no
    // path through the if/case leaves a value unassigned and infers a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign full_o = (cnt_q == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the DMEM port between the MEM stage (zero-latency) and a debug/DMA
// requester (one exclusive slot). Optional starvation guard: DMEM_ARB_STARVE_EN.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_W,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  p_addr,
    input  logic [DATA_WIDTH-1:0]  p_wdata,
    input  logic [MEM_WRITE_W-1:0] p_mem_write,
    input  logic [MEM_READ_W-1:0]  p_mem_read,
    output logic [DATA_WIDTH-1:0]  p_rdata,
    output logic                   p_stall,
    input  logic                   d_req_valid,
    output logic                   d_req_ready,
    input  logic [DATA_WIDTH-1:0]  d_addr,
    input  logic [DATA_WIDTH-1:0]  d_wdata,
    input  logic [MEM_WRITE_W-1:0] d_mem_write,
    input  logic [MEM_READ_W-1:0]  d_mem_read,
    output logic                   d_rsp_valid,
    input  logic                   d_rsp_ready,
    output logic [DATA_WIDTH-1:0]  d_rsp_rdata,
    output logic [DATA_WIDTH-1:0]  m_addr,
    output logic [DATA_WIDTH-1:0]  m_wdata,
    output logic [MEM_WRITE_W-1:0] m_mem_write,
    output logic [MEM_READ_W-1:0]  m_mem_read,
    input  logic [DATA_WIDTH-1:0]  m_rdata
);

    darb_state_e           state_q, state_d;
    mem_op_t               p_op, d_op, req_op_q, req_op_d;
    logic [DATA_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [DATA_WIDTH-1:0] req_wdata_q, req_wdata_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  p_active, accept, starve_full;

    assign p_op     = '{wr: p_mem_write, rd: p_mem_read};
    assign d_op     = '{wr: d_mem_write, rd: d_mem_read};
    assign p_active = op_active(p_op);

    always_comb begin
        state_d     = state_q;
        req_op_d    = req_op_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        m_addr      = p_addr;
        m_wdata     = p_wdata;
        m_mem_write = p_mem_write;
        m_mem_read  = p_mem_read;
        p_stall     = 1'b0;
        d_req_ready = 1'b0;
        d_rsp_valid = 1'b0;
        accept      = 1'b0;
        unique case (state_q)
            DARB_IDLE: begin
                // Ready is gated by rst_n so nothing is offered while in reset.
                d_req_ready = rst_n && (!p_active || starve_full);
                accept      = d_req_valid && d_req_ready;
                if (accept) begin
                    req_op_d    = d_op;
                    req_addr_d  = d_addr;
                    req_wdata_d = d_wdata;
                    state_d     = DARB_D_ACC;
                end
            end
            DARB_D_ACC: begin
                m_addr      = req_addr_q;
                m_wdata     = req_wdata_q;
                m_mem_write = req_op_q.wr;
                // A request carrying both ops is a store.
                m_mem_read  = (req_op_q.wr != '0) ? '0 : req_op_q.rd;
                p_stall     = p_active;
                if ((req_op_q.wr == '0) && (req_op_q.rd != '0)) begin
                    rsp_rdata_d = m_rdata;
                end else begin
                    rsp_rdata_d = '0;
                end
                state_d = DARB_D_RSP;
            end
            DARB_D_RSP: begin
                d_rsp_valid = 1'b1;
                if (d_rsp_ready) begin
                    state_d = DARB_IDLE;
                end
            end
            default: state_d = DARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= DARB_IDLE;
            req_op_q    <= '0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            req_op_q    <= req_op_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign p_rdata     = m_rdata;
    assign d_rsp_rdata = rsp_rdata_q;

`ifdef DMEM_ARB_STARVE_EN
    logic starve_clr;

    assign starve_clr = (state_q != DARB_IDLE) || !d_req_valid || accept;

    dmem_arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (starve_clr),
        .inc_i (p_active),
        .full_o(starve_full)
    );
`else
    // Without the guard the pipeline always wins; the limit is unused.
    logic unused_starve_limit;

    assign starve_full         = 1'b0;
    assign unused_starve_limit = ^STARVE_LIMIT;
`endif

endmodule
